// File: rtl/bist_resp_ctrl_if.sv
// bist_resp_ctrl_if: start/response inputs and sequencing/status outputs of the BIST response controller
interface bist_resp_ctrl_if #(
  parameter int OUT_BITS = 2,
  parameter int CNT_BITS = 8
);
  logic                start;
  logic [OUT_BITS-1:0] CUT_OP;
  logic [OUT_BITS-1:0] FF_OP;
  logic                TPG_EN;
  logic                TPG_RST;
  logic                FIL_INC;
  logic                FIL_END;
  logic                busy;
  logic                done;
  logic                det_valid;
  logic                det_flag;
  logic [CNT_BITS-1:0] fault_idx;
  logic [CNT_BITS-1:0] detected_cnt;
  modport master (
    input  start, CUT_OP, FF_OP,
    output TPG_EN, TPG_RST, FIL_INC, FIL_END, busy, done, det_valid, det_flag, fault_idx, detected_cnt
  );
  modport slave (
    output start, CUT_OP, FF_OP,
    input  TPG_EN, TPG_RST, FIL_INC, FIL_END, busy, done, det_valid, det_flag, fault_idx, detected_cnt
  );
endinterface

// File: rtl/bist_resp_ctrl.sv
// bist_resp_ctrl: sequences faults and patterns, compares faulty vs fault-free responses, counts detected faults
module bist_resp_ctrl #(
  parameter int OUT_BITS     = 2,
  parameter int NUM_FAULTS   = 22,
  parameter int NUM_PATTERNS = 31,
  parameter int CNT_BITS     = 8,
  parameter int EARLY_EXIT   = 1
) (
  input logic clk,
  input logic rst,
  bist_resp_ctrl_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] APPLY  = 3'd2;
  localparam logic [2:0] RECORD = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [CNT_BITS-1:0] LAST_PAT   = CNT_BITS'(NUM_PATTERNS - 1);
  localparam logic [CNT_BITS-1:0] LAST_FAULT = CNT_BITS'(NUM_FAULTS - 1);
  logic [2:0]          state_q, state_d;
  logic [CNT_BITS-1:0] pat_cnt_q, fault_idx_q, detected_cnt_q;
  logic                hit_q;
  logic                tpg_en_q, tpg_rst_q, fil_inc_q, fil_end_q, busy_q, done_q, det_valid_q, det_flag_q;
  logic [OUT_BITS-1:0] diff;
  logic                mis, launch;
  assign diff   = bus.CUT_OP ^ bus.FF_OP;
  assign mis    = |diff;
  assign launch = bus.start && (state_q == IDLE || state_q == DONE);
  // next-state: one fault = LOAD, APPLY x k, RECORD, then NEXT or FINISH
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start ? LOAD : IDLE;
      LOAD:    state_d = APPLY;
      APPLY:   state_d = (pat_cnt_q == LAST_PAT || (EARLY_EXIT != 0 && mis)) ? RECORD : APPLY;
      RECORD:  state_d = (fault_idx_q == LAST_FAULT) ? FINISH : NEXT;
      NEXT:    state_d = LOAD;
      FINISH:  state_d = DONE;
      DONE:    state_d = bus.start ? LOAD : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, counters and outputs; outputs are decoded from the next state so they come straight off flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pat_cnt_q      <= '0;
      hit_q          <= 1'b0;
      fault_idx_q    <= '0;
      detected_cnt_q <= '0;
      tpg_en_q       <= 1'b0;
      tpg_rst_q      <= 1'b0;
      fil_inc_q      <= 1'b0;
      fil_end_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      det_valid_q    <= 1'b0;
      det_flag_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pat_cnt_q      <= (state_q == APPLY) ? pat_cnt_q + 1'b1 : '0;
      hit_q          <= (state_q == APPLY) ? (hit_q | mis) : (state_q == RECORD) ? hit_q : 1'b0;
      fault_idx_q    <= launch ? '0 : (state_q == NEXT) ? fault_idx_q + 1'b1 : fault_idx_q;
      detected_cnt_q <= launch ? '0 : (state_q == RECORD) ? detected_cnt_q + CNT_BITS'(hit_q) : detected_cnt_q;
      tpg_en_q       <= state_d == APPLY;
      tpg_rst_q      <= state_d == LOAD;
      fil_inc_q      <= state_d == NEXT;
      fil_end_q      <= state_d == DONE;
      busy_q         <= state_d != IDLE && state_d != DONE;
      done_q         <= state_d == DONE;
      det_valid_q    <= state_d == RECORD;
      det_flag_q     <= state_d == RECORD && (hit_q | mis);
    end
  end
  assign bus.TPG_EN       = tpg_en_q;
  assign bus.TPG_RST      = tpg_rst_q;
  assign bus.FIL_INC      = fil_inc_q;
  assign bus.FIL_END      = fil_end_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.det_valid    = det_valid_q;
  assign bus.det_flag     = det_flag_q;
  assign bus.fault_idx    = fault_idx_q;
  assign bus.detected_cnt = detected_cnt_q;
endmodule

// File: tb/tb_bist_resp_ctrl.sv
// tb_bist_resp_ctrl: directed campaigns on three parameterisations with a small TPG/FIL response model
module tb_bist_resp_ctrl;
  localparam int EN = 7, TR = 6, INC = 5, FEND = 4, BUSY = 3, DONE = 2, DV = 1, DF = 0;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       start_r [3];
  logic [7:0] st [3];
  logic [7:0] fidx_w [3];
  logic [7:0] dcnt_w [3];
  logic [7:0] pat_e [3];
  logic [1:0] ff_w [3];
  logic [1:0] cut_w [3];
  logic [3:0] mis_tab [3][3];
  bist_resp_ctrl_if #(.OUT_BITS(2), .CNT_BITS(8)) b0 ();
  bist_resp_ctrl_if #(.OUT_BITS(2), .CNT_BITS(8)) b1 ();
  bist_resp_ctrl_if #(.OUT_BITS(2), .CNT_BITS(8)) b2 ();
  bist_resp_ctrl #(.OUT_BITS(2), .NUM_FAULTS(3), .NUM_PATTERNS(4), .CNT_BITS(8), .EARLY_EXIT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  bist_resp_ctrl #(.OUT_BITS(2), .NUM_FAULTS(3), .NUM_PATTERNS(4), .CNT_BITS(8), .EARLY_EXIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  bist_resp_ctrl #(.OUT_BITS(2), .NUM_FAULTS(3), .NUM_PATTERNS(1), .CNT_BITS(8), .EARLY_EXIT(0)) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  assign b0.start = start_r[0];
  assign b1.start = start_r[1];
  assign b2.start = start_r[2];
  assign b0.CUT_OP = cut_w[0];
  assign b1.CUT_OP = cut_w[1];
  assign b2.CUT_OP = cut_w[2];
  assign b0.FF_OP = ff_w[0];
  assign b1.FF_OP = ff_w[1];
  assign b2.FF_OP = ff_w[2];
  assign st[0] = {b0.TPG_EN, b0.TPG_RST, b0.FIL_INC, b0.FIL_END, b0.busy, b0.done, b0.det_valid, b0.det_flag};
  assign st[1] = {b1.TPG_EN, b1.TPG_RST, b1.FIL_INC, b1.FIL_END, b1.busy, b1.done, b1.det_valid, b1.det_flag};
  assign st[2] = {b2.TPG_EN, b2.TPG_RST, b2.FIL_INC, b2.FIL_END, b2.busy, b2.done, b2.det_valid, b2.det_flag};
  assign fidx_w[0] = b0.fault_idx;
  assign fidx_w[1] = b1.fault_idx;
  assign fidx_w[2] = b2.fault_idx;
  assign dcnt_w[0] = b0.detected_cnt;
  assign dcnt_w[1] = b1.detected_cnt;
  assign dcnt_w[2] = b2.detected_cnt;
  // pattern generator model: reseeded by TPG_RST, stepped by TPG_EN
  always @(posedge clk)
    for (int u = 0; u < 3; u++)
      pat_e[u] <= (rst || st[u][TR]) ? 8'd0 : pat_e[u] + 8'(st[u][EN]);
  // faulty CUT model: flips bit 0 on the (fault, pattern) pairs marked in mis_tab
  always_comb
    for (int u = 0; u < 3; u++) begin
      ff_w[u]  = pat_e[u][1:0];
      cut_w[u] = ff_w[u] ^ {1'b0, st[u][EN] && pat_e[u] < 8'd4 && fidx_w[u] < 8'd3 && mis_tab[u][fidx_w[u][1:0]][pat_e[u][1:0]]};
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic camp(input int u, input string tag, input logic [2:0] ef, input int ec, input int ecyc, input int een, input int poke);
    int cyc, en, inc, dv;
    logic [2:0] fl;
    cyc = 0; en = 0; inc = 0; dv = 0; fl = '0;
    @(negedge clk) start_r[u] = 1'b1;
    @(negedge clk) start_r[u] = 1'b0;
    chk({tag, ":load"}, {st[u][TR], st[u][BUSY], st[u][FEND], st[u][DONE]}, 4'b1100);
    chk({tag, ":fidx0"}, fidx_w[u], 0);
    chk({tag, ":dcnt0"}, dcnt_w[u], 0);
    while (!st[u][DONE] && cyc < 200) begin
      if (st[u][DV]) begin
        fl = {fl[1:0], st[u][DF]};
        dv++;
      end
      en += int'(st[u][EN]);
      inc += int'(st[u][INC]);
      start_r[u] = (cyc == poke);
      @(negedge clk) cyc++;
    end
    start_r[u] = 1'b0;
    chk({tag, ":cycles"}, cyc, ecyc);
    chk({tag, ":flags"}, fl, ef);
    chk({tag, ":verdicts"}, dv, 3);
    chk({tag, ":tpg_en"}, en, een);
    chk({tag, ":fil_inc"}, inc, 2);
    chk({tag, ":detected"}, dcnt_w[u], ec);
    chk({tag, ":end_lvls"}, {st[u][FEND], st[u][DONE], st[u][BUSY]}, 3'b110);
  endtask
  initial begin
    int t;
    for (int u = 0; u < 3; u++) begin
      start_r[u] = 1'b0;
      for (int f = 0; f < 3; f++) mis_tab[u][f] = 4'b0000;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_outs", st[u], 0);
      chk("rst_cnts", {fidx_w[u], dcnt_w[u]}, 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_outs", st[0], 0);
    camp(0, "clean", 3'b000, 0, 21, 12, -1);
    mis_tab[0][1] = 4'b0010;
    camp(0, "f1p2", 3'b010, 1, 21, 12, -1);
    camp(0, "busy_start", 3'b010, 1, 21, 12, 10);
    @(negedge clk) start_r[0] = 1'b1;
    @(negedge clk) start_r[0] = 1'b0;
    t = 0;
    while (!(fidx_w[0] == 8'd1 && st[0][EN]) && t < 100) begin
      @(negedge clk) t++;
    end
    chk("mid_reach", t < 100, 1);
    #1 rst = 1'b1;
    #1 chk("mid_rst_outs", st[0], 0);
    chk("mid_rst_cnts", {fidx_w[0], dcnt_w[0]}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", st[0], 0);
    camp(0, "rerun", 3'b010, 1, 21, 12, -1);
    for (int f = 0; f < 3; f++) mis_tab[1][f] = 4'b0001;
    camp(1, "early", 3'b111, 3, 12, 3, -1);
    mis_tab[2][0] = 4'b0001;
    mis_tab[2][2] = 4'b0001;
    camp(2, "np1", 3'b101, 2, 12, 3, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
